// File: rtl/pipelined_mux_tree.sv
// -----------------------------------------------------------------------------
// pipelined_mux_tree
//
// WIDTH-bit, N_IN:1 multiplexer built as a binary tree of 2:1 levels. A
// register stage is inserted after every STAGE_LEVELS tree levels. Every stage
// carries a valid bit and takes part in a valid/ready chain, so the block can
// stall, collapse bubbles and be flushed. The still-unused select bits travel
// with the partial results, so a new selection can be accepted every cycle.
//
// Latency is L = ceil(LEVELS / STAGE_LEVELS) register stages, where
// LEVELS = $clog2(N_IN). Up to L entries can be in flight, in FIFO order.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (clears valid, data, sel)
//   in_data    in   N_IN*WIDTH  input i at bits [i*WIDTH +: WIDTH]
//   sel        in   LEVELS      index of the input to forward
//   in_valid   in   in_data/sel valid this cycle
//   in_ready   out  block accepts the input this cycle (combinational)
//   flush      in   synchronous: discard every in-flight entry and the
//                   input presented in the same cycle
//   out_data   out  WIDTH       selected data (registered)
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module pipelined_mux_tree #(
  parameter int WIDTH        = 64,
  parameter int N_IN         = 8,
  parameter int STAGE_LEVELS = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_IN*WIDTH-1:0]      in_data,
  input  logic [$clog2(N_IN)-1:0]    sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int L      = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;
  localparam int DW     = N_IN * WIDTH;

  // Stage registers. Every stage keeps a full-width word vector; words above
  // the number that survive a stage are always zero, so they reduce to
  // constants in synthesis.
  logic [DW-1:0]     r_data    [L];
  logic [LEVELS-1:0] r_sel     [L];
  logic [L-1:0]      r_valid;

  logic [DW-1:0]     w_comb    [L];
  logic [LEVELS-1:0] w_sel_nxt [L];
  logic [L-1:0]      w_up_valid;
  logic [L-1:0]      w_ready;

  // Applies tree levels lo..hi-1 to a word vector. Level k halves the number
  // of live words: word j becomes word 2j (sel bit 0) or 2j+1 (sel bit 1).
  function automatic logic [DW-1:0] reduce_levels(
    input logic [DW-1:0]     src,
    input logic [LEVELS-1:0] s_sel,
    input int                lo,
    input int                hi
  );
    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;
    cur = src;
    for (int k = 0; k < LEVELS; k++) begin
      if (k >= lo && k < hi) begin
        nxt = '0;
        for (int j = 0; j < N_IN / 2; j++) begin
          if (j < (N_IN >> (k + 1))) begin
            nxt[j*WIDTH +: WIDTH] = s_sel[k] ? cur[(2*j+1)*WIDTH +: WIDTH]
                                             : cur[(2*j)*WIDTH +: WIDTH];
          end
        end
        cur = nxt;
      end
    end
    return cur;
  endfunction

  // Select bits already consumed are zeroed before being registered; only the
  // upper bits are needed further down the tree.
  function automatic logic [LEVELS-1:0] drop_used_sel(
    input logic [LEVELS-1:0] s_sel,
    input int                hi
  );
    logic [LEVELS-1:0] m;
    m = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (k >= hi) begin
        m[k] = s_sel[k];
      end
    end
    return m;
  endfunction

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_stage
      localparam int LO = gi * STAGE_LEVELS;
      localparam int HI = ((gi + 1) * STAGE_LEVELS < LEVELS) ? (gi + 1) * STAGE_LEVELS : LEVELS;
      if (gi == 0) begin : g_first
        assign w_comb[gi]     = reduce_levels(in_data, sel, LO, HI);
        assign w_sel_nxt[gi]  = drop_used_sel(sel, HI);
        assign w_up_valid[gi] = in_valid;
      end else begin : g_next
        assign w_comb[gi]     = reduce_levels(r_data[gi-1], r_sel[gi-1], LO, HI);
        assign w_sel_nxt[gi]  = drop_used_sel(r_sel[gi-1], HI);
        assign w_up_valid[gi] = r_valid[gi-1];
      end
    end
  endgenerate

  // Ready ripples from the output back to the input: a stage can load when it
  // is empty or when its occupant moves on this cycle. An empty stage is
  // always ready, which is what collapses bubbles under a downstream stall.
  always_comb begin : p_ready
    logic w_down_ready;
    w_ready      = '0;
    w_down_ready = out_ready;
    for (int s = L - 1; s >= 0; s--) begin
      w_ready[s]   = ~r_valid[s] | w_down_ready;
      w_down_ready = w_ready[s];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int s = 0; s < L; s++) begin
        r_data[s] <= '0;
        r_sel[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        if (w_ready[s]) begin
          r_valid[s] <= w_up_valid[s];
          // Payload only moves with a real entry; bubbles leave it untouched
          // so an idle sel (possibly X) never reaches the registers.
          if (w_up_valid[s]) begin
            r_data[s] <= w_comb[s];
            r_sel[s]  <= w_sel_nxt[s];
          end
        end
      end
      // Flush overrides every load, including the input of this cycle.
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[L-1];
  assign out_data  = r_data[L-1][WIDTH-1:0];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mux_tree
//
// Three instances of pipelined_mux_tree (WIDTH=16, N_IN=8) with
// STAGE_LEVELS = 1, 2, 3 (latency 3, 2, 1). Only one instance carries traffic
// at a time. Accepted inputs push the expected word (direct index into
// in_data) onto a scoreboard queue; each output transfer pops and compares.
// -----------------------------------------------------------------------------
module tb_pipelined_mux_tree;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = 3;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } exp_t;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic           flush   = 1'b0;
  logic [N*W-1:0] in_data  [3];
  logic [SW-1:0]  sel      [3];
  logic [W-1:0]   out_data [3];
  logic [2:0]     in_valid;
  logic [2:0]     in_ready;
  logic [2:0]     out_valid;
  logic [2:0]     out_ready;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      pipelined_mux_tree #(
        .WIDTH        (W),
        .N_IN         (N),
        .STAGE_LEVELS (gi + 1)
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data[gi]),
        .sel       (sel[gi]),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .flush     (flush),
        .out_data  (out_data[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi])
      );
    end
  endgenerate

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_ref_data(input int d);
    for (int i = 0; i < N; i++) in_data[d][i*W +: W] = W'(16'hA000 + i);
  endtask

  task automatic set_rand_data(input int d);
    for (int i = 0; i < N; i++) in_data[d][i*W +: W] = W'($urandom);
  endtask

  // One clock cycle on instance d. Called just after a falling edge with the
  // inputs already driven; samples handshakes before the rising edge.
  // lat >= 0 also checks accept-to-consume distance in cycles.
  task automatic step(input int d, input int lat);
    exp_t e;
    #1;
    if (out_valid[d] && out_ready[d]) begin
      n_out++;
      $display("tx dut%0d cyc %0d out_data %h", d, cyc, out_data[d]);
      if (sb_q.size() == 0) begin
        check_value("spurious_out", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_value("out_data", out_data[d], e.data);
        if (lat >= 0) check_value("latency", cyc - e.acc, lat);
      end
    end
    if (flush) begin
      sb_q.delete();
    end else if (in_valid[d] && in_ready[d]) begin
      e.data = in_data[d][int'(sel[d])*W +: W];
      e.acc  = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int   seq [4];
    int   idx;
    logic acc;
    int   n_before;
    int   lat;

    for (int d = 0; d < 3; d++) begin
      in_data[d] = '0;
      sel[d]     = '0;
    end
    in_valid  = '0;
    out_ready = '0;
    set_ref_data(0);

    // ---- 1. reset, including an asynchronous reset mid-stream ----
    #2;
    check_value("rst_out_valid", out_valid[0], 0);
    check_value("rst_out_data", out_data[0], 0);
    check_value("rst_in_ready", in_ready[0], 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid[0] = 1'b1;
    sel[0] = 3'd1;
    step(0, -1);
    sel[0] = 3'd2;
    step(0, -1);
    in_valid[0] = 1'b0;
    step(0, -1);
    #1;
    check_value("pre_rst_valid", out_valid[0], 1);
    check_value("pre_rst_data", out_data[0], 16'hA001);
    #1 reset_n = 1'b0;
    #1;
    check_value("mid_rst_out_valid", out_valid[0], 0);
    check_value("mid_rst_out_data", out_data[0], 0);
    check_value("mid_rst_in_ready", in_ready[0], 1);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready[0] = 1'b1;
    repeat (6) step(0, -1);
    check_value("post_rst_idle", out_valid[0], 0);

    // ---- 2. sweep sel=0..7 back to back, latency 3, no gaps ----
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = 1'b1;
      sel[0] = SW'(i);
      step(0, 3);
    end
    in_valid[0] = 1'b0;
    repeat (5) step(0, 3);
    check_value("sweep_drained", sb_q.size(), 0);

    // ---- 3. backpressure: 5 stalled cycles, then release ----
    seq = '{3, 5, 6, 1};
    idx = 0;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (idx < 4);
      sel[0] = SW'(seq[idx < 4 ? idx : 3]);
      #1;
      check_value("bp_in_ready", in_ready[0], (c < 3) ? 1 : 0);
      if (c >= 3) begin
        check_value("bp_hold_valid", out_valid[0], 1);
        check_value("bp_hold_data", out_data[0], 16'hA003);
      end
      acc = in_valid[0] & in_ready[0];
      step(0, -1);
      if (acc) idx++;
    end
    out_ready[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid[0] = (idx < 4);
      sel[0] = SW'(seq[idx < 4 ? idx : 3]);
      #1;
      acc = in_valid[0] & in_ready[0];
      step(0, -1);
      if (acc) idx++;
    end
    check_value("bp_all_accepted", idx, 4);
    check_value("bp_drained", sb_q.size(), 0);

    // ---- 4. bubble collapse under a stalled output ----
    out_ready[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid[0] = (c == 0 || c == 2);
      sel[0] = (c == 0) ? 3'd2 : 3'd7;
      #1;
      check_value("bub_in_ready", in_ready[0], 1);
      step(0, -1);
    end
    in_valid[0] = 1'b1;
    sel[0] = 3'd0;
    #1;
    check_value("bub_in_ready_2occ", in_ready[0], 1);
    check_value("bub_head_valid", out_valid[0], 1);
    check_value("bub_head_data", out_data[0], 16'hA002);
    step(0, -1);
    sel[0] = 3'd4;
    #1;
    check_value("bub_full", in_ready[0], 0);
    step(0, -1);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    repeat (5) step(0, -1);
    check_value("bub_drained", sb_q.size(), 0);

    // ---- 5. flush with a full pipe and a simultaneous input ----
    out_ready[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid[0] = 1'b1;
      sel[0] = SW'(i);
      step(0, -1);
    end
    sel[0] = 3'd5;
    flush = 1'b1;
    out_ready[0] = 1'b1;
    n_before = n_out;
    #1;
    check_value("flush_in_ready", in_ready[0], 1);
    step(0, -1);
    flush = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check_value("flush_cleared", out_valid[0], 0);
    step(0, -1);
    in_valid[0] = 1'b1;
    sel[0] = 3'd4;
    step(0, -1);
    in_valid[0] = 1'b0;
    repeat (5) step(0, -1);
    check_value("flush_out_count", n_out - n_before, 2);
    check_value("flush_drained", sb_q.size(), 0);

    // ---- 6. other stage splits: random traffic, then latency ----
    for (int d = 1; d < 3; d++) begin
      lat = (d == 1) ? 2 : 1;
      for (int c = 0; c < 150; c++) begin
        set_rand_data(d);
        sel[d]       = SW'($urandom_range(0, 7));
        in_valid[d]  = ($urandom_range(0, 9) < 7);
        out_ready[d] = ($urandom_range(0, 9) < 6);
        step(d, -1);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      repeat (4) step(d, -1);
      for (int c = 0; c < 10; c++) begin
        set_rand_data(d);
        sel[d]      = SW'($urandom_range(0, 7));
        in_valid[d] = 1'b1;
        step(d, lat);
      end
      in_valid[d] = 1'b0;
      repeat (4) step(d, lat);
      check_value("param_drained", sb_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
